// File: rtl/posit_chk_pkg.sv
// posit_chk_pkg: shared state type, constants and helpers for the posit result checker
package posit_chk_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_e;
  localparam int DEF_TOL = 1;
  localparam int DEF_TIMEOUT = 1024;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/posit_abs_diff.sv
// posit_abs_diff: unsigned absolute difference of two N-bit words
module posit_abs_diff #(
  parameter int N = 36
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d
);
  assign d = a > b ? a - b : b - a;
endmodule

// File: rtl/posit_result_checker.sv
// posit_result_checker: compares a DUT result stream against a reference ROM with tolerance, timeout and error capture
module posit_result_checker
  import posit_chk_pkg::*;
#(
  parameter int N       = 36,
  parameter int SAMPLES = 10000,
  parameter int TOL     = DEF_TOL,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int AW      = clog2(SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  dut_out,
  input  logic          dut_done,
  output logic [AW-1:0] ref_addr,
  input  logic [N-1:0]  ref_data,
  output logic          busy,
  output logic          finished,
  output logic          pass,
  output logic [AW-1:0] err_count,
  output logic [AW-1:0] cmp_count,
  output logic [AW-1:0] first_err_idx,
  output logic [N-1:0]  first_err_got,
  output logic [N-1:0]  first_err_exp,
  output logic          timeout,
  output logic          extra_done
);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [N-1:0] TOL_N = N'(TOL);
  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, err_q, err_d, cmp_q, cmp_d, fidx_q, fidx_d;
  logic [N-1:0] fgot_q, fgot_d, fexp_q, fexp_d, diff;
  logic [TW-1:0] timer_q, timer_d;
  logic timeout_q, timeout_d, extra_q, extra_d, pass_q, pass_d;
  logic run, hit, mism;
  posit_abs_diff #(.N(N)) u_diff (.a(ref_data), .b(dut_out), .d(diff));
  assign run = state_q == RUN;
  assign hit = run && dut_done;
  assign mism = diff > TOL_N;
  assign ref_addr = hit ? idx_q + 1'b1 : idx_q;
  assign busy = state_q == PRIME || state_q == RUN;
  assign finished = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign cmp_count = cmp_q;
  assign first_err_idx = fidx_q;
  assign first_err_got = fgot_q;
  assign first_err_exp = fexp_q;
  assign timeout = timeout_q;
  assign extra_done = extra_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    cmp_d = cmp_q;
    fidx_d = fidx_q;
    fgot_d = fgot_q;
    fexp_d = fexp_q;
    timer_d = timer_q;
    timeout_d = timeout_q;
    extra_d = extra_q;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d = PRIME;
      idx_d = '0;
      err_d = '0;
      cmp_d = '0;
      fidx_d = '0;
      fgot_d = '0;
      fexp_d = '0;
      timer_d = '0;
      timeout_d = 1'b0;
      extra_d = 1'b0;
    end
    if (state_q == PRIME) state_d = RUN;
    if (dut_done && !run) extra_d = 1'b1;
    if (hit) begin
      cmp_d = &cmp_q ? cmp_q : cmp_q + 1'b1;
      err_d = mism && !(&err_q) ? err_q + 1'b1 : err_q;
      if (mism && err_q == '0) begin
        fidx_d = idx_q;
        fgot_d = dut_out;
        fexp_d = ref_data;
      end
      idx_d = idx_q + 1'b1;
      timer_d = '0;
      if (idx_q == AW'(SAMPLES - 1)) state_d = DONE;
    end else if (run) begin
      timer_d = timer_q == TW'(TIMEOUT - 1) ? timer_q : timer_q + 1'b1;
      timeout_d = timer_q == TW'(TIMEOUT - 1) ? 1'b1 : timeout_q;
      state_d = timer_q == TW'(TIMEOUT - 1) ? DONE : state_q;
    end
    pass_d = state_d == DONE && err_d == '0 && !timeout_d && !extra_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= '0;
      cmp_q <= '0;
      fidx_q <= '0;
      fgot_q <= '0;
      fexp_q <= '0;
      timer_q <= '0;
      timeout_q <= 1'b0;
      extra_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      cmp_q <= cmp_d;
      fidx_q <= fidx_d;
      fgot_q <= fgot_d;
      fexp_q <= fexp_d;
      timer_q <= timer_d;
      timeout_q <= timeout_d;
      extra_q <= extra_d;
      pass_q <= pass_d;
    end
  end
endmodule
